// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store); DM has fixed priority.
// Optional grant/wait performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       if_grant_cnt,
  output logic [31:0]       dm_grant_cnt,
  output logic [31:0]       wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       owner_dm;
  logic [7:0] wait_q;
  logic       ack_hit, to_hit;

  assign ack_hit = (state == BUSY) && mem_ack;
  assign to_hit  = (state == BUSY) && !mem_ack && (wait_q == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dm_req || if_req) state_nxt = BUSY;
      BUSY:    if (ack_hit || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm  <= 1'b0;
      wait_q    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_q <= '0;
          if (dm_req) begin
            owner_dm  <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            owner_dm  <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        BUSY: begin
          // ack on the final allowed cycle still wins over the abort
          if (ack_hit || to_hit) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner_dm) dm_rdata <= ack_hit ? mem_rdata : '0;
            else          if_rdata <= ack_hit ? mem_rdata : '0;
            if (to_hit) err <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dm_ready    = (state == DONE) && owner_dm;
  assign if_ready    = (state == DONE) && !owner_dm;
  assign freeze_pipe = dm_req & ~dm_ready;
  assign freeze_if   = freeze_pipe | (if_req & ~if_ready);

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (state == IDLE && dm_req)            dm_grant_cnt <= dm_grant_cnt + 32'd1;
      if (state == IDLE && !dm_req && if_req) if_grant_cnt <= if_grant_cnt + 32'd1;
      if (state == BUSY)                      wait_cnt     <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (priority, latency = 2 + ack cycle, memory contents, sticky err).
module tb_mem_port_arbiter;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_ready, dm_ready, mem_en, mem_we, mem_ack, freeze_if, freeze_pipe, err;
  logic        resp_ack = 1'b0, manual_ack = 1'b0;
  bit          resp_en = 1'b1;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_grant_cnt, dm_grant_cnt, wait_cnt;
`endif

  assign mem_ack = resp_en ? resp_ack : manual_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .freeze_if(freeze_if), .freeze_pipe(freeze_pipe), .err(err)
`ifdef MEM_ARB_PERF_EN
    , .if_grant_cnt(if_grant_cnt), .dm_grant_cnt(dm_grant_cnt), .wait_cnt(wait_cnt)
`endif
  );

  int total = 0, bad = 0;

  // memory contents seen by the responder, and the bench's own expectation of them
  logic [31:0] mem_arr [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  int          dly_q[$];
  int          cur_dly = 1, bcnt = 0, b_len = 0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_we = 1'b0;
  bit          b_stable = 1'b1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // responder: delay d acks on the d-th cycle mem_en is high, d = 0 never acks
  always @(posedge clk) begin
    #1;
    if (mem_en === 1'b1) begin
      if (bcnt == 0) begin
        cur_dly  = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
        b_addr   = mem_addr; b_we = mem_we; b_wdata = mem_wdata; b_stable = 1'b1;
      end else if (mem_addr !== b_addr || mem_we !== b_we || mem_wdata !== b_wdata) begin
        b_stable = 1'b0;
      end
      bcnt++;
      b_len = bcnt;
      if (bcnt == cur_dly) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
        resp_ack  = 1'b1;
      end else begin
        mem_rdata = $urandom;
        resp_ack  = 1'b0;
      end
    end else begin
      bcnt     = 0;
      resp_ack = 1'b0;
    end
  end

  logic fp_log [0:63], fi_log [0:63], en_log [0:63], err_log [0:63];

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
  endtask

  // cycle 1 is the IDLE/grant cycle; returns -1 if no ready within maxc cycles
  task automatic wait_ready(input bit dm, input int maxc, output int cyc, output bit other);
    cyc = -1; other = 1'b0;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      fp_log[n] = freeze_pipe; fi_log[n] = freeze_if; en_log[n] = mem_en; err_log[n] = err;
      if ((dm ? if_ready : dm_ready) === 1'b1) other = 1'b1;
      if ((dm ? dm_ready : if_ready) === 1'b1) begin cyc = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({mem_en, mem_we, if_ready, dm_ready, err, freeze_if, freeze_pipe} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000000",
                      {mem_en, mem_we, if_ready, dm_ready, err, freeze_if, freeze_pipe}); end
    total++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'd0) begin
      bad++; $display("FAIL reset_data got=%h %h %h %h want=0", mem_addr, mem_wdata, if_rdata, dm_rdata); end
    sync(); rst = 1'b0;
  endtask

  task automatic test_single_load();
    int cyc; bit oth;
    mem_arr[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
    sync(); dly_q.push_back(1);
    drive(0, 0, 1, 0, 32'h100, 0);
    wait_ready(1, 20, cyc, oth);
    total++; if (cyc !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", cyc); end
    total++; if (dm_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h want=deadbeef", dm_rdata); end
    total++; if ({en_log[1], en_log[2], en_log[3]} !== 3'b010 || b_addr !== 32'h100) begin
      bad++; $display("FAIL load_mem_en got=%b addr=%h want=010 addr=100", {en_log[1], en_log[2], en_log[3]}, b_addr); end
    total++; if ({fp_log[1], fp_log[2], fp_log[3]} !== 3'b110) begin
      bad++; $display("FAIL load_freeze_pipe got=%b want=110", {fp_log[1], fp_log[2], fp_log[3]}); end
    sync(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (dm_ready !== 1'b0) begin bad++; $display("FAIL load_pulse_width got=%b want=0", dm_ready); end
  endtask

  task automatic test_simultaneous();
    int cyc; bit oth;
    sync(); dly_q.push_back(2); dly_q.push_back(2);
    drive(1, 32'h40, 1, 1, 32'h200, 32'h12345678);
    wait_ready(1, 20, cyc, oth);
    total++; if (cyc !== 4 || oth !== 1'b0) begin bad++; $display("FAIL simul_dm_first got=%0d/%0b want=4/0", cyc, oth); end
    total++; if (b_we !== 1'b1 || b_wdata !== 32'h12345678 || b_addr !== 32'h200) begin
      bad++; $display("FAIL simul_dm_store got=%b %h %h want=1 12345678 200", b_we, b_wdata, b_addr); end
    ref_mem[32'h200] = 32'h12345678;
    sync(); dm_req = 1'b0;
    wait_ready(0, 20, cyc, oth);
    total++; if (cyc !== 4 || oth !== 1'b0) begin bad++; $display("FAIL simul_if_after got=%0d/%0b want=4/0", cyc, oth); end
    total++; if (if_rdata !== ref_rd(32'h40) || b_addr !== 32'h40 || b_we !== 1'b0) begin
      bad++; $display("FAIL simul_if_data got=%h @%h want=%h @40", if_rdata, b_addr, ref_rd(32'h40)); end
    sync(); if_req = 1'b0;
  endtask

  task automatic test_fetch_wait();
    int cyc; bit oth; bit fi_ok;
    sync(); dly_q.push_back(5);
    drive(1, 32'h8, 0, 0, 0, 0);
    wait_ready(0, 30, cyc, oth);
    total++; if (cyc !== 7) begin bad++; $display("FAIL fetch_latency got=%0d want=7", cyc); end
    total++; if (b_len !== 5 || b_stable !== 1'b1 || b_addr !== 32'h8) begin
      bad++; $display("FAIL fetch_hold got=len%0d stable%0b %h want=len5 stable1 8", b_len, b_stable, b_addr); end
    fi_ok = 1'b1;
    for (int n = 1; n <= 6; n++) if (fi_log[n] !== 1'b1) fi_ok = 1'b0;
    total++; if (fi_ok !== 1'b1 || fi_log[7] !== 1'b0) begin bad++; $display("FAIL fetch_freeze_if got=%0b/%0b want=1/0", fi_ok, fi_log[7]); end
    total++; if (if_rdata !== ref_rd(32'h8)) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", if_rdata, ref_rd(32'h8)); end
    sync(); if_req = 1'b0;
    @(negedge clk);
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width got=%b want=0", if_ready); end
  endtask

  task automatic test_timeout();
    int cyc; bit oth;
    sync(); dly_q.push_back(0);
    drive(0, 0, 1, 0, 32'h300, 0);
    wait_ready(1, 40, cyc, oth);
    total++; if (cyc !== 2 + TO) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", cyc, 2 + TO); end
    total++; if (err !== 1'b1 || err_log[cyc > 1 ? cyc - 1 : 1] !== 1'b0) begin
      bad++; $display("FAIL timeout_err got=%b (before %b) want=1 (before 0)", err, err_log[cyc > 1 ? cyc - 1 : 1]); end
    total++; if (dm_rdata !== 32'd0 || b_len !== TO) begin bad++; $display("FAIL timeout_rdata got=%h len%0d want=0 len%0d", dm_rdata, b_len, TO); end
    sync(); dly_q.push_back(1);
    drive(1, 32'h10, 0, 0, 0, 0);
    wait_ready(0, 20, cyc, oth);
    total++; if (err !== 1'b1 || cyc !== 3) begin bad++; $display("FAIL timeout_sticky got=%b/%0d want=1/3", err, cyc); end
    sync(); if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit rdy;
    resp_en = 1'b0;
    sync(); drive(0, 0, 1, 0, 32'h500, 0);
    sync(); rst = 1'b1;
    sync(); rst = 1'b0; manual_ack = 1'b1; mem_rdata = 32'hCAFEF00D; dm_req = 1'b0;
    @(negedge clk);
    total++; if ({mem_en, mem_we, err, dm_ready, if_ready} !== 5'd0 || {mem_addr, dm_rdata, if_rdata} !== 96'd0) begin
      bad++; $display("FAIL reset_mid got=%b %h %h %h want=0", {mem_en, mem_we, err, dm_ready, if_ready}, mem_addr, dm_rdata, if_rdata); end
    sync(); manual_ack = 1'b0;
    rdy = 1'b0;
    repeat (3) begin @(negedge clk); if (dm_ready || if_ready || mem_en) rdy = 1'b1; end
    total++; if (rdy !== 1'b0 || dm_rdata !== 32'd0) begin bad++; $display("FAIL reset_mid_quiet got=%b %h want=0 0", rdy, dm_rdata); end
    resp_en = 1'b1;
  endtask

  task automatic test_random();
    int cyc; bit oth;
    logic [31:0] ia, da, dd, if_exp, dm_exp;
    bit dw, err_exp, dm_known;
    int kind, dd_dly, id_dly;
    rst = 1'b1; sync(); sync(); rst = 1'b0;
    err_exp = 1'b0; if_exp = '0; dm_exp = '0; dm_known = 1'b1;
    for (int it = 0; it < 40; it++) begin
      kind   = $urandom_range(0, 2);
      ia     = 32'($urandom_range(0, 7)) << 2;
      da     = 32'($urandom_range(0, 7)) << 2;
      dd     = $urandom;
      dw     = 1'($urandom_range(0, 1));
      dd_dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      id_dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      sync();
      if (kind != 0) dly_q.push_back(dd_dly);
      if (kind != 1) dly_q.push_back(id_dly);
      drive(kind != 1, ia, kind != 0, dw, da, dd);
      if (kind != 0) begin
        if (dd_dly == 0) begin err_exp = 1'b1; dm_exp = '0; dm_known = 1'b1; end
        else if (dw) begin ref_mem[da] = dd; dm_known = 1'b0; end
        else begin dm_exp = ref_rd(da); dm_known = 1'b1; end
        wait_ready(1, 30, cyc, oth);
        total++; if (cyc !== 2 + (dd_dly == 0 ? TO : dd_dly) || oth !== 1'b0 || b_addr !== da) begin
          bad++; $display("FAIL rnd_dm it=%0d got=%0d/%0b @%h want=%0d/0 @%h", it, cyc, oth, b_addr, 2 + (dd_dly == 0 ? TO : dd_dly), da); end
        if (dm_known) begin
          total++; if (dm_rdata !== dm_exp) begin bad++; $display("FAIL rnd_dm_rdata it=%0d got=%h want=%h", it, dm_rdata, dm_exp); end
        end
        total++; if (if_rdata !== if_exp) begin bad++; $display("FAIL rnd_if_keep it=%0d got=%h want=%h", it, if_rdata, if_exp); end
        sync(); dm_req = 1'b0;
      end
      if (kind != 1) begin
        if (id_dly == 0) begin err_exp = 1'b1; if_exp = '0; end
        else if_exp = ref_rd(ia);
        wait_ready(0, 30, cyc, oth);
        total++; if (cyc !== 2 + (id_dly == 0 ? TO : id_dly) || oth !== 1'b0 || b_addr !== ia) begin
          bad++; $display("FAIL rnd_if it=%0d got=%0d/%0b @%h want=%0d/0 @%h", it, cyc, oth, b_addr, 2 + (id_dly == 0 ? TO : id_dly), ia); end
        total++; if (if_rdata !== if_exp) begin bad++; $display("FAIL rnd_if_rdata it=%0d got=%h want=%h", it, if_rdata, if_exp); end
        if (dm_known) begin
          total++; if (dm_rdata !== dm_exp) begin bad++; $display("FAIL rnd_dm_keep it=%0d got=%h want=%h", it, dm_rdata, dm_exp); end
        end
        sync(); if_req = 1'b0;
      end
      total++; if (err !== err_exp) begin bad++; $display("FAIL rnd_err it=%0d got=%b want=%b", it, err, err_exp); end
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    int cyc; bit oth;
    rst = 1'b1; sync(); sync(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sync(); dly_q.push_back(2);
      drive(k < 3, 32'h20, k >= 3, 0, 32'h24, 0);
      wait_ready(k >= 3, 20, cyc, oth);
      sync(); drive(0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    total++; if (if_grant_cnt !== 32'd3) begin bad++; $display("FAIL perf_if got=%0d want=3", if_grant_cnt); end
    total++; if (dm_grant_cnt !== 32'd2) begin bad++; $display("FAIL perf_dm got=%0d want=2", dm_grant_cnt); end
    total++; if (wait_cnt !== 32'd10) begin bad++; $display("FAIL perf_wait got=%0d want=10", wait_cnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_simultaneous();
    test_fetch_wait();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
